// File: rtl/mandel_pkg.sv
// Shared constants and FSM encoding for the Mandelbrot frame scheduler.
package mandel_pkg;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;
    localparam int unsigned COORD_W   = 10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer;
// the pointer moves past the granted index only when the grant is accepted.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N-1:0]    req_i,
    input  logic            accept_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] scan_idx;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        scan_idx    = '0;
        for (int k = 0; k < int'(N); k++) begin
            scan_idx = IdxW'((32'(rr_q) + 32'(k)) % N);
            if (!gnt_valid_o && req_i[scan_idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = scan_idx;
            end
        end
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
        rr_d = rr_q;
        if (accept_i && gnt_valid_o) begin
            rr_d = (32'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/mandel_scheduler.sv
// Frame job scheduler: walks (x, y), dispatches pixel jobs to NCORES cores and serialises
// their results onto the framebuffer write port. MANDEL_SCHED_PERF_EN adds frame_cycles.
module mandel_scheduler
    import mandel_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEF,
    parameter int unsigned V_RES  = V_RES_DEF,
    parameter int unsigned NCORES = 4,
    parameter int unsigned ITER_W = 8,
    parameter int unsigned ADDR_W = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
`ifdef MANDEL_SCHED_PERF_EN
    output logic [31:0]              frame_cycles,
`endif
    output logic [NCORES-1:0]        job_valid,
    input  logic [NCORES-1:0]        job_ready,
    output logic [COORD_W-1:0]       job_x,
    output logic [COORD_W-1:0]       job_y,
    input  logic [NCORES-1:0]        res_valid,
    input  logic [NCORES*ITER_W-1:0] res_iter,
    output logic [NCORES-1:0]        res_ack,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [ITER_W-1:0]        fb_data,
    input  logic                     fb_ready
);

    localparam int unsigned IdxW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] Total = CntW'(H_RES * V_RES);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] tag_x_q [NCORES];
    logic [COORD_W-1:0] tag_x_d [NCORES];
    logic [COORD_W-1:0] tag_y_q [NCORES];
    logic [COORD_W-1:0] tag_y_d [NCORES];
    logic [NCORES-1:0]  out_q, out_d;
    logic [CntW-1:0]    issued_q, issued_d, written_q, written_d;
    logic               fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic [ITER_W-1:0]  fb_data_q, fb_data_d;

    logic               collect, accept, dispatch, disp_found, gnt_valid;
    logic [NCORES-1:0]  gnt, avail;
    logic [IdxW-1:0]    gnt_idx, disp_idx;
    logic [31:0]        addr_full;

    assign collect = (state_q == StRun) || (state_q == StDrain);
    assign busy    = collect;
    assign done    = (state_q == StDone);
    assign job_x   = x_q;
    assign job_y   = y_q;
    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;

    rr_arbiter #(
        .N (NCORES)
    ) u_rr_arbiter (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (res_valid & out_q & {NCORES{collect}}),
        .accept_i    (accept),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // A grant may only load the output register when it is empty or emptying now.
    assign accept  = gnt_valid && (!fb_we_q || fb_ready);
    assign res_ack = accept ? gnt : '0;

    // A core whose result is popped this cycle may be re-dispatched in the same cycle.
    assign avail = job_ready & ~(out_q & ~res_ack);

    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int i = int'(NCORES) - 1; i >= 0; i--) begin
            if (avail[i]) begin
                disp_found = 1'b1;
                disp_idx   = IdxW'(i);
            end
        end
        dispatch  = (state_q == StRun) && disp_found;
        job_valid = '0;
        if (dispatch) begin
            job_valid[disp_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        tag_x_d   = tag_x_q;
        tag_y_d   = tag_y_q;
        out_d     = out_q;
        issued_d  = issued_q;
        written_d = written_q;
        fb_we_d   = fb_we_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        addr_full = 32'(tag_y_q[gnt_idx]) * H_RES + 32'(tag_x_q[gnt_idx]);

        if (fb_we_q && fb_ready) begin
            fb_we_d   = 1'b0;
            written_d = written_q + 1'b1;
        end
        if (accept) begin
            out_d[gnt_idx] = 1'b0;
            fb_we_d        = 1'b1;
            fb_addr_d      = addr_full[ADDR_W-1:0];
            fb_data_d      = res_iter[gnt_idx * ITER_W +: ITER_W];
        end
        if (dispatch) begin
            tag_x_d[disp_idx] = x_q;
            tag_y_d[disp_idx] = y_q;
            out_d[disp_idx]   = 1'b1;
            issued_d          = issued_q + 1'b1;
            if (x_q == COORD_W'(H_RES - 1)) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    x_d       = '0;
                    y_d       = '0;
                    out_d     = '0;
                    issued_d  = '0;
                    written_d = '0;
                end
            end
            StRun: begin
                if (dispatch && (issued_q == Total - 1'b1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((written_q == Total) && !fb_we_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            tag_x_q   <= '{default: '0};
            tag_y_q   <= '{default: '0};
            out_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            tag_x_q   <= tag_x_d;
            tag_y_q   <= tag_y_d;
            out_q     <= out_d;
            issued_q  <= issued_d;
            written_q <= written_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == StIdle) && start) begin
            cyc_d = '0;
        end else if (busy && (cyc_q != '1)) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign frame_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mandel_scheduler.sv
// Directed bench for mandel_scheduler on a 4x2 frame with two modelled iteration cores.
module tb_mandel_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int NC = 2;
    localparam int IW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset, start, busy, done;
    logic [NC-1:0] job_valid, job_ready, res_valid, res_ack;
    logic [9:0]    job_x, job_y;
    logic [NC*IW-1:0] res_iter;
    logic          fb_we, fb_ready;
    logic [AW-1:0] fb_addr;
    logic [IW-1:0] fb_data;
`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0]   frame_cycles;
`endif

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mandel_scheduler #(
        .H_RES  (H),
        .V_RES  (V),
        .NCORES (NC),
        .ITER_W (IW),
        .ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
`ifdef MANDEL_SCHED_PERF_EN
        .frame_cycles (frame_cycles),
`endif
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_x        (job_x),
        .job_y        (job_y),
        .res_valid    (res_valid),
        .res_iter     (res_iter),
        .res_ack      (res_ack),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_ready     (fb_ready)
    );

    // Core model: accepts a job when idle, raises its result three edges later.
    logic [NC-1:0] busy_c, resv, res_gate;
    logic [1:0]    cnt [NC];
    logic [9:0]    rx [NC];
    logic [9:0]    ry [NC];

    assign job_ready = ~busy_c;
    assign res_valid = resv & res_gate;
    assign res_iter  = {8'(rx[1] + ry[1]), 8'(rx[0] + ry[0])};

    always @(posedge clk) begin
        if (reset) begin
            busy_c <= '0;
            resv   <= '0;
            for (int i = 0; i < NC; i++) begin
                cnt[i] <= '0;
                rx[i]  <= '0;
                ry[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (res_ack[i]) begin
                    resv[i]   <= 1'b0;
                    busy_c[i] <= 1'b0;
                end else if (job_valid[i] && job_ready[i]) begin
                    busy_c[i] <= 1'b1;
                    cnt[i]    <= 2'd2;
                    rx[i]     <= job_x;
                    ry[i]     <= job_y;
                end else if (busy_c[i] && !resv[i]) begin
                    if (cnt[i] == 2'd0) resv[i] <= 1'b1;
                    else cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

    // Write/ack monitor; addr = y*4+x so the expected data is addr[1:0] + addr[3:2].
    logic       mon_clr;
    int         wr_cnt, done_cnt, data_err, n_ack;
    int         hits [8];
    logic [3:0] wr_log [16];
    logic [1:0] ack_log [16];

    always @(posedge clk) begin
        if (mon_clr) begin
            wr_cnt   <= 0;
            done_cnt <= 0;
            data_err <= 0;
            n_ack    <= 0;
            for (int i = 0; i < 8; i++) hits[i] <= 0;
        end else begin
            if (fb_we && fb_ready) begin
                wr_cnt <= wr_cnt + 1;
                if (wr_cnt < 16) wr_log[wr_cnt[3:0]] <= fb_addr;
                if (!fb_addr[3]) hits[fb_addr[2:0]] <= hits[fb_addr[2:0]] + 1;
                if (fb_data !== ({6'd0, fb_addr[1:0]} + {6'd0, fb_addr[3:2]}))
                    data_err <= data_err + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (|res_ack) begin
                if (n_ack < 16) ack_log[n_ack[3:0]] <= res_ack;
                n_ack <= n_ack + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_writes"}, 32'(wr_cnt), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_hits%0d", tag, i), 32'(hits[i]), 32'd1);
        chk({tag, "_data_err"}, 32'(data_err), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_we_after"}, 32'(fb_we), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; fb_ready = 1'b1; res_gate = 2'b11; mon_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_job_valid", 32'(job_valid), 32'd0);
        chk("rst_res_ack", 32'(res_ack), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        chk("rst_job_xy", {job_y, job_x}, 32'd0);
        reset = 1'b0;
        clear_mon();

        // Basic frame and dispatch order
        pulse_start();
        chk("run_busy", 32'(busy), 32'd1);
        chk("disp0_valid", 32'(job_valid), 32'b01);
        chk("disp0_xy", {job_y, job_x}, 32'd0);
        @(negedge clk);
        chk("disp1_valid", 32'(job_valid), 32'b10);
        chk("disp1_xy", {job_y, job_x}, 32'd1);
        @(negedge clk);
        chk("both_outstanding", 32'(job_valid), 32'd0);
        wait_done("basic");
        check_frame("basic");

        // Round-robin: core1's result released first, then both held valid
        do_reset();
        res_gate = 2'b00;
        clear_mon();
        pulse_start();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_no_job", 32'(job_valid), 32'd0);
        end
        res_gate = 2'b10;
        @(negedge clk);
        res_gate = 2'b00;
        repeat (6) @(negedge clk);
        res_gate = 2'b11;
        wait_done("rr");
        chk("rr_ack0", 32'(ack_log[0]), 32'b10);
        chk("rr_ack1", 32'(ack_log[1]), 32'b01);
        chk("rr_ack2", 32'(ack_log[2]), 32'b10);
        chk("rr_ack3", 32'(ack_log[3]), 32'b01);
        chk("rr_addr0", 32'(wr_log[0]), 32'd1);
        chk("rr_addr1", 32'(wr_log[1]), 32'd0);
        chk("rr_addr2", 32'(wr_log[2]), 32'd2);
        chk("rr_addr3", 32'(wr_log[3]), 32'd3);
        check_frame("rr");

        // Backpressure with a write pending and another result waiting
        do_reset();
        res_gate = 2'b10;
        fb_ready = 1'b0;
        clear_mon();
        pulse_start();
        n = 0;
        while (!fb_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_we_rise", 32'(fb_we), 32'd1);
        res_gate = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_we_hold", 32'(fb_we), 32'd1);
            chk("bp_addr_hold", 32'(fb_addr), 32'd1);
            chk("bp_data_hold", 32'(fb_data), 32'd1);
            chk("bp_no_ack", 32'(res_ack), 32'd0);
        end
        fb_ready = 1'b1;
        wait_done("bp");
        check_frame("bp");

        // Reset after three writes, then a clean frame with a stray start in RUN
        do_reset();
        clear_mon();
        pulse_start();
        n = 0;
        while (wr_cnt < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_three_writes", 32'(wr_cnt >= 3), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_we", 32'(fb_we), 32'd0);
        chk("mid_job_valid", 32'(job_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        clear_mon();
        pulse_start();
        repeat (3) @(negedge clk);
        chk("restart_busy", 32'(busy), 32'd1);
        pulse_start();
        wait_done("restart");
        check_frame("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
